// File: rtl/vending_credit.sv
// Coin-credit vending controller: accumulates credit, vends priced items, returns change one unit per pulse.
// All outputs registered (one edge after the causing strobe); overflow or short-credit errors light redlight for ERR_CYCLES.
module vending_credit #(
    parameter int ERR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coin_valid,
    input  logic [1:0]  coin_code,
    input  logic        sel_valid,
    input  logic [1:0]  sel_item,
    input  logic        cancel,
    output logic [10:0] number,
    output logic        redlight,
    output logic        vend_valid,
    output logic [1:0]  vend_item,
    output logic        change_pulse,
    output logic        coin_reject,
    output logic        busy
);

    localparam int TW = (ERR_CYCLES < 1) ? 1 : $clog2(ERR_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t          state;
    logic [3:0]      credit;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [3:0]      coin_val;
    logic [3:0]      price;
    logic [4:0]      coin_sum;
    logic            accepting;
    logic            cancel_eff;
    logic            coin_over;
    logic            err;

    always_comb begin
        coin_val = 4'd1;
        case (coin_code)
            2'd0: coin_val = 4'd1;
            2'd1: coin_val = 4'd2;
            2'd2: coin_val = 4'd5;
            2'd3: coin_val = 4'd10;
            default: coin_val = 4'd1;
        endcase
        price = 4'd3;
        case (sel_item)
            2'd0: price = 4'd3;
            2'd1: price = 4'd5;
            2'd2: price = 4'd7;
            2'd3: price = 4'd12;
            default: price = 4'd3;
        endcase
    end

    // A cancel with no credit is treated as absent, so lower-priority strobes still act.
    assign accepting  = (state == IDLE) || (state == CREDIT);
    assign cancel_eff = cancel && (state == CREDIT);
    assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};
    assign coin_over  = coin_sum > 5'd15;
    assign err        = accepting && !cancel_eff &&
                        ((sel_valid && (credit < price)) ||
                         (!sel_valid && coin_valid && coin_over));

    always_comb begin
        timer_nxt = timer;
        if (err)
            timer_nxt = TW'(ERR_CYCLES);
        else if (timer != '0)
            timer_nxt = timer - TW'(1);
    end

    assign number = {7'd0, credit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= 4'd0;
            timer        <= '0;
            redlight     <= 1'b0;
            vend_valid   <= 1'b0;
            vend_item    <= 2'd0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            vend_valid   <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            timer        <= timer_nxt;
            redlight     <= (timer_nxt != '0);
            case (state)
                IDLE, CREDIT: begin
                    if (cancel_eff) begin
                        state       <= CHANGE;
                        busy        <= 1'b1;
                        coin_reject <= coin_valid;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (credit >= price) begin
                            credit     <= credit - price;
                            state      <= VEND;
                            busy       <= 1'b1;
                            vend_valid <= 1'b1;
                            vend_item  <= sel_item;
                        end
                    end else if (coin_valid) begin
                        if (coin_over) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit <= coin_sum[3:0];
                            state  <= (coin_sum != 5'd0) ? CREDIT : IDLE;
                        end
                    end
                end
                VEND: begin
                    coin_reject <= coin_valid;
                    if (credit != 4'd0) begin
                        state <= CHANGE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    if (credit != 4'd0) begin
                        credit       <= credit - 4'd1;
                        change_pulse <= 1'b1;
                        if (credit == 4'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_credit.sv
// Directed bench for vending_credit: coin accumulation, vend and change, overflow/short-credit errors, priority, reset.
module tb_vending_credit;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid;
    logic [1:0]  coin_code;
    logic        sel_valid;
    logic [1:0]  sel_item;
    logic        cancel;
    logic [10:0] number;
    logic        redlight;
    logic        vend_valid;
    logic [1:0]  vend_item;
    logic        change_pulse;
    logic        coin_reject;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vending_credit #(.ERR_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .cancel       (cancel),
        .number       (number),
        .redlight     (redlight),
        .vend_valid   (vend_valid),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        coin_valid = 1'b0; coin_code = 2'd0;
        sel_valid  = 1'b0; sel_item  = 2'd0;
        cancel     = 1'b0;
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1; coin_code = code;
        tick();
        clear_in();
    endtask

    task automatic sel(input logic [1:0] item);
        sel_valid = 1'b1; sel_item = item;
        tick();
        clear_in();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        tick();
        chk("rst_number", number, 0);
        chk("rst_redlight", redlight, 0);
        chk("rst_vend_valid", vend_valid, 0);
        chk("rst_vend_item", vend_item, 0);
        chk("rst_change", change_pulse, 0);
        chk("rst_reject", coin_reject, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Coins 5,5,2 then item 1 (price 5): vend, 7 change pulses.
        coin(2'd2); chk("c31_n5", number, 5);
        coin(2'd2); chk("c31_n10", number, 10);
        coin(2'd1); chk("c31_n12", number, 12);
        chk("c31_busy_credit", busy, 0);
        sel(2'd1);
        chk("c31_vend", vend_valid, 1);
        chk("c31_vend_item", vend_item, 1);
        chk("c31_n7", number, 7);
        chk("c31_busy_vend", busy, 1);
        tick();
        chk("c31_vend_off", vend_valid, 0);
        chk("c31_n7_hold", number, 7);
        chk("c31_no_pulse_yet", change_pulse, 0);
        chk("c31_busy_change", busy, 1);
        for (int i = 6; i >= 0; i--) begin
            tick();
            chk("c31_pulse", change_pulse, 1);
            chk("c31_count", number, i);
        end
        tick();
        chk("c31_pulse_end", change_pulse, 0);
        chk("c31_idle_busy", busy, 0);
        chk("c31_idle_n", number, 0);

        // Credit 12, coin 5 overflows.
        do_reset();
        coin(2'd3); coin(2'd1);
        chk("c32_n12", number, 12);
        coin(2'd2);
        chk("c32_reject", coin_reject, 1);
        chk("c32_n12_hold", number, 12);
        chk("c32_red1", redlight, 1);
        tick();
        chk("c32_reject_off", coin_reject, 0);
        chk("c32_red2", redlight, 1);
        tick(); chk("c32_red3", redlight, 1);
        tick(); chk("c32_red4", redlight, 1);
        tick(); chk("c32_red_off", redlight, 0);
        chk("c32_n_final", number, 12);

        // Credit 3, item 3 (price 12) short, retrigger after 2 cycles.
        do_reset();
        coin(2'd1); coin(2'd0);
        chk("c33_n3", number, 3);
        sel(2'd3);
        chk("c33_no_vend", vend_valid, 0);
        chk("c33_n3_hold", number, 3);
        chk("c33_red1", redlight, 1);
        tick(); chk("c33_red2", redlight, 1);
        sel(2'd3);
        chk("c33_red3", redlight, 1);
        tick(); chk("c33_red4", redlight, 1);
        tick(); chk("c33_red5", redlight, 1);
        tick(); chk("c33_red6", redlight, 1);
        tick(); chk("c33_red_off", redlight, 0);
        chk("c33_busy", busy, 0);

        // Credit 7, cancel + sel + coin together: cancel wins.
        do_reset();
        coin(2'd2); coin(2'd1);
        chk("c34_n7", number, 7);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd2; coin_valid = 1'b1; coin_code = 2'd0;
        tick();
        clear_in();
        chk("c34_reject", coin_reject, 1);
        chk("c34_no_vend", vend_valid, 0);
        chk("c34_n7_hold", number, 7);
        chk("c34_busy", busy, 1);
        chk("c34_red", redlight, 0);
        for (int i = 6; i >= 0; i--) begin
            tick();
            chk("c34_pulse", change_pulse, 1);
            chk("c34_count", number, i);
            chk("c34_no_vend_chg", vend_valid, 0);
            chk("c34_red_chg", redlight, 0);
        end
        tick();
        chk("c34_pulse_end", change_pulse, 0);
        chk("c34_idle", busy, 0);

        // Credit 10, item 0 (price 3), coin during CHANGE rejected.
        do_reset();
        coin(2'd3);
        sel(2'd0);
        chk("c35_vend", vend_valid, 1);
        chk("c35_item", vend_item, 0);
        chk("c35_n7", number, 7);
        tick();
        chk("c35_change_entry", number, 7);
        coin(2'd3);
        chk("c35_reject", coin_reject, 1);
        chk("c35_pulse1", change_pulse, 1);
        chk("c35_n6", number, 6);
        chk("c35_red", redlight, 0);
        for (int i = 5; i >= 0; i--) begin
            tick();
            chk("c35_pulse", change_pulse, 1);
            chk("c35_count", number, i);
        end
        tick();
        chk("c35_pulse_end", change_pulse, 0);
        chk("c35_idle", busy, 0);

        // Credit 9, cancel, reset after 3 pulses.
        do_reset();
        coin(2'd2); coin(2'd1); coin(2'd1);
        chk("c36_n9", number, 9);
        cancel = 1'b1;
        tick();
        clear_in();
        chk("c36_busy", busy, 1);
        for (int i = 8; i >= 6; i--) begin
            tick();
            chk("c36_pulse", change_pulse, 1);
            chk("c36_count", number, i);
        end
        rst = 1'b1;
        tick();
        chk("c36_rst_n", number, 0);
        chk("c36_rst_pulse", change_pulse, 0);
        chk("c36_rst_busy", busy, 0);
        chk("c36_rst_red", redlight, 0);
        chk("c36_rst_vend", vend_valid, 0);
        chk("c36_rst_reject", coin_reject, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c36_no_pulse", change_pulse, 0);
            chk("c36_n0", number, 0);
        end

        // Cancel with no credit does nothing.
        cancel = 1'b1;
        tick();
        clear_in();
        chk("idle_cancel_busy", busy, 0);
        tick();
        chk("idle_cancel_pulse", change_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vending_credit.md
VENDING_CREDIT -- requirements
Module: vending_credit

Interface
REQ-001 Parameter: ERR_CYCLES, default 4, number of cycles redlight is held after an error event.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: coin_valid  input  1  one-cycle coin insertion strobe.
REQ-005 Port: coin_code  input  2  coin value code: 0=1, 1=2, 2=5, 3=10 credit units.
REQ-006 Port: sel_valid  input  1  one-cycle item selection strobe.
REQ-007 Port: sel_item  input  2  item code; price: 0=3, 1=5, 2=7, 3=12 units.
REQ-008 Port: cancel  input  1  one-cycle refund request strobe.
REQ-009 Port: number  output  11  current credit, zero-extended, registered; feeds the display block.
REQ-010 Port: redlight  output  1  error indicator, registered; feeds the display block.
REQ-011 Port: vend_valid  output  1  one-cycle dispense pulse.
REQ-012 Port: vend_item  output  2  item being dispensed, valid with vend_valid.
REQ-013 Port: change_pulse  output  1  one pulse per credit unit returned.
REQ-014 Port: coin_reject  output  1  one-cycle pulse, coin returned unaccepted.
REQ-015 Port: busy  output  1  high in VEND and CHANGE states.

Function
REQ-016 The block SHALL implement states IDLE (credit 0), CREDIT (credit >0), VEND, CHANGE; all outputs SHALL be registered, responding on the edge after the causing input.
REQ-017 Credit SHALL never exceed 15, so number is always within the display's two-digit range 0..15.
REQ-018 In IDLE/CREDIT, a coin with credit+value <= 15 SHALL add value to credit on the next edge; IDLE->CREDIT when result >0.
REQ-019 In IDLE/CREDIT, a coin with credit+value > 15 SHALL leave credit unchanged, pulse coin_reject for one cycle, and (re)load the redlight timer.
REQ-020 In IDLE/CREDIT, sel_valid with credit >= price SHALL on the next edge subtract price from credit, enter VEND, and assert vend_valid with vend_item=sel_item for exactly that one VEND cycle.
REQ-021 sel_valid with credit < price SHALL leave credit and state unchanged and (re)load the redlight timer.
REQ-022 From VEND the block SHALL go to CHANGE if remaining credit >0, else to IDLE, after one cycle.
REQ-023 cancel in CREDIT SHALL enter CHANGE on the next edge; cancel in IDLE SHALL be ignored.
REQ-024 In CHANGE, each edge SHALL decrement credit by 1 and assert change_pulse for the following cycle; reaching 0 SHALL enter IDLE, giving exactly N consecutive pulses for credit N.
REQ-025 Simultaneous strobes in IDLE/CREDIT: priority cancel > sel_valid > coin_valid; lower-priority coin SHALL be rejected (coin_reject pulse, no redlight), lower-priority sel ignored.
REQ-026 coin_valid in VEND or CHANGE SHALL produce a coin_reject pulse, no credit change, no redlight; sel_valid and cancel there SHALL be ignored.
REQ-027 Redlight timer SHALL load ERR_CYCLES on each error event; redlight=1 while timer >0, timer decrements each cycle, independent of state; retrigger restarts the full count.
REQ-028 Credit arithmetic SHALL be 4-bit internally with number[10:4]=0 at all times.

Reset
REQ-029 With rst high on an edge: state IDLE, credit 0, timer 0, number=0, redlight=0, vend_valid=0, vend_item=0, change_pulse=0, coin_reject=0, busy=0.
REQ-030 Reset SHALL take priority over all inputs; reset mid-CHANGE SHALL discard remaining credit with no further change_pulse.

Verification
REQ-031 Coins 5,5,2 then sel_item=1 -> number 5,10,12, vend_valid one cycle with vend_item=1, number 7, then 7 change_pulse cycles counting number 6..0, IDLE.
REQ-032 Credit 12, coin 5 -> coin_reject one cycle, number stays 12, redlight high exactly 4 cycles.
REQ-033 Credit 3, sel_item=3 -> no vend, number 3, redlight 4 cycles; second error after 2 cycles -> redlight total 6 cycles.
REQ-034 Credit 7, cancel+sel_item=2+coin 1 same cycle -> cancel wins, coin_reject pulse, 7 change_pulses, no vend_valid, redlight stays 0.
REQ-035 Credit 10, sel_item=0 then coin during CHANGE -> coin_reject, credit path unaffected, exactly 7 pulses total.
REQ-036 Credit 9, cancel, rst after 3 change_pulses -> number 0, no further pulses, all outputs at reset values.
